irq_ctrl: RTL

Parametrised, vectored, nestable interrupt controller. It generalises the CPU's fixed four-line interrupt scheme to NUM_IRQ channels and adds per-channel edge/level mode, a software mask, fixed priority and nesting. It sits between peripheral interrupt sources and the CPU control unit. It presents one request, a vector and an id, and accepts acknowledge and return-from-interrupt strobes from the CPU.

---
 rtl/irq_ctrl_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM states and
// a lowest-set-bit helper used by the priority encoders.
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int unsigned MAX_IRQ = 16;

   // Scans from the top down so the last hit is the lowest index.
   function automatic logic [3:0] lowestSetIdx(input logic [MAX_IRQ-1:0] vec);
      lowestSetIdx = '0;
      for (int unsigned i = MAX_IRQ; i > 0; i--) begin
         if (vec[i-1]) lowestSetIdx = 4'(i - 1);
      end
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit, with a valid flag.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec,
   output logic          valid,
   output logic [IW-1:0] index
);

   logic [MAX_IRQ-1:0] padded;
   logic [3:0]         idx;

   always_comb begin
      padded        = '0;
      padded[N-1:0] = vec;
   end

   assign idx   = lowestSetIdx(padded);
   assign valid = |vec;
   assign index = idx[IW-1:0];

endmodule

// File: rtl/irq_ctrl.sv
// Vectored, nestable interrupt controller with per-channel edge/level mode,
// software mask and fixed lowest-index-first priority.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned               NUM_IRQ     = 4,
   parameter int unsigned               VECT_WIDTH  = 16,
   parameter logic [VECT_WIDTH-1:0]     VECT_BASE   = VECT_WIDTH'(16'h0008),
   parameter int unsigned               VECT_STRIDE = 4,
   parameter logic [NUM_IRQ-1:0]        EDGE_MASK   = '1,
   parameter logic [NUM_IRQ-1:0]        MASK_RESET  = '0,
   localparam int unsigned              IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_IRQ-1:0]    irq_in,
   input  logic                  global_en,
   input  logic                  mask_wr_en,
   input  logic [NUM_IRQ-1:0]    mask_wr_data,
   output logic [NUM_IRQ-1:0]    mask_out,
   output logic [NUM_IRQ-1:0]    pending_out,
   output logic [NUM_IRQ-1:0]    active_out,
   output logic                  irq_req,
   output logic [VECT_WIDTH-1:0] irq_vector,
   output logic [IDW-1:0]        irq_id,
   input  logic                  irq_ack,
   output logic [NUM_IRQ-1:0]    irq_clr,
   input  logic                  irq_reti
);

   state_t                 state;
   logic [NUM_IRQ-1:0]     prevIn;
   logic [NUM_IRQ-1:0]     pending;
   logic [NUM_IRQ-1:0]     active;
   logic [NUM_IRQ-1:0]     mask;
   logic [NUM_IRQ-1:0]     irqEvent;
   logic [NUM_IRQ-1:0]     eligible;
   logic [NUM_IRQ-1:0]     idOneHot;
   logic [NUM_IRQ-1:0]     retiClr;
   logic [NUM_IRQ-1:0]     ackSet;
   logic                   candValid;
   logic [IDW-1:0]         candIdx;
   logic                   actValid;
   logic [IDW-1:0]         actIdx;
   logic                   allowed;
   logic [VECT_WIDTH-1:0]  candVector;

   irq_prio_enc #(.N(NUM_IRQ)) eligEnc (
      .vec   (eligible),
      .valid (candValid),
      .index (candIdx)
   );

   irq_prio_enc #(.N(NUM_IRQ)) actEnc (
      .vec   (active),
      .valid (actValid),
      .index (actIdx)
   );

   assign irqEvent   = (irq_in & ~prevIn & EDGE_MASK) | (irq_in & ~EDGE_MASK);
   assign eligible   = pending & mask;
   assign allowed    = candValid && (!actValid || (candIdx < actIdx));
   assign candVector = VECT_BASE + VECT_WIDTH'(candIdx) * VECT_WIDTH'(VECT_STRIDE);
   assign idOneHot   = NUM_IRQ'(1) << irq_id;
   assign retiClr    = (irq_reti && actValid) ? (NUM_IRQ'(1) << actIdx) : '0;
   assign ackSet     = (state == ACK) ? idOneHot : '0;

   // Retire the innermost handler before marking the newly granted one, so a
   // reti coinciding with ACK never clears the channel being granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prevIn  <= '0;
         pending <= '0;
         active  <= '0;
         mask    <= MASK_RESET;
      end else begin
         prevIn  <= irq_in;
         pending <= (pending & ~ackSet) | irqEvent;
         active  <= (active & ~retiClr) | ackSet;
         if (mask_wr_en) mask <= mask_wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         irq_req    <= 1'b0;
         irq_id     <= '0;
         irq_vector <= VECT_BASE;
         irq_clr    <= '0;
      end else begin
         irq_clr <= '0;
         case (state)
            IDLE: begin
               if (global_en && allowed) begin
                  state      <= REQ;
                  irq_req    <= 1'b1;
                  irq_id     <= candIdx;
                  irq_vector <= candVector;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  state   <= ACK;
                  irq_req <= 1'b0;
                  irq_clr <= idOneHot;
               end else if (!global_en) begin
                  state   <= IDLE;
                  irq_req <= 1'b0;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               irq_req <= 1'b0;
            end
         endcase
      end
   end

   assign mask_out    = mask;
   assign pending_out = pending;
   assign active_out  = active;

endmodule
